// File: rtl/hdma_pkg.sv
// Shared definitions for the Game Boy DMA family.
// States, MMIO register offsets and control bit positions.
package gb_dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HB_WAIT,
      S_RD,
      S_WAIT,
      S_WR,
      S_NEXT
   } state_t;

   localparam logic [2:0] REG_SRC_HI = 3'd0;
   localparam logic [2:0] REG_SRC_LO = 3'd1;
   localparam logic [2:0] REG_DST_HI = 3'd2;
   localparam logic [2:0] REG_DST_LO = 3'd3;
   localparam logic [2:0] REG_CTRL   = 3'd4;

   localparam int MODE_BIT = 7;

endpackage

// File: rtl/hdma_if.sv
// MMIO, H-blank and shared-bus signals of the VRAM block-transfer unit.
// master is the DMA unit, slave is the CPU/bus side.
interface hdma_if;

   logic        mmio_wr;
   logic [2:0]  mmio_a;
   logic [7:0]  mmio_din;
   logic [7:0]  mmio_dout;
   logic        hblank_start;
   logic        dma_rd;
   logic        dma_wr;
   logic [15:0] dma_a;
   logic [7:0]  dma_din;
   logic [7:0]  dma_dout;
   logic        cpu_stall;
   logic        dma_occupy_extbus;
   logic        dma_occupy_vidbus;

   modport master (
      input  mmio_wr, mmio_a, mmio_din, hblank_start, dma_din,
      output mmio_dout, dma_rd, dma_wr, dma_a, dma_dout,
      output cpu_stall, dma_occupy_extbus, dma_occupy_vidbus
   );

   modport slave (
      output mmio_wr, mmio_a, mmio_din, hblank_start, dma_din,
      input  mmio_dout, dma_rd, dma_wr, dma_a, dma_dout,
      input  cpu_stall, dma_occupy_extbus, dma_occupy_vidbus
   );

endinterface

// File: rtl/hdma_mover.sv
// Byte engine: RD/WAIT/WR/NEXT sequencing with source/destination counters.
// Block-boundary decisions come from the control level through end_sel.
module hdma_mover
   import gb_dma_pkg::*;
#(
   parameter int BLOCK_BYTES = 16,
   parameter int ACCESS_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go_rd,
   input  logic        go_hb,
   input  logic        abort_hb,
   input  logic        hblank_start,
   input  logic        load,
   input  logic [15:0] src_init,
   input  logic [12:0] dst_init,
   input  state_t      end_sel,
   input  logic [7:0]  dma_din,
   output state_t      state,
   output logic        blk_end,
   output logic [15:0] src_cur,
   output logic        dma_rd,
   output logic        dma_wr,
   output logic [15:0] dma_a,
   output logic [7:0]  dma_dout
);

   localparam int LOG = $clog2(BLOCK_BYTES);
   localparam logic [2:0] WLAST =
      3'((ACCESS_WAIT > 0) ? ACCESS_WAIT - 1 : 0);

   state_t      state_nx;
   logic [15:0] src;
   logic [12:0] dst;
   logic [2:0]  wcnt;
   logic        last;

   assign last    = &src[LOG-1:0];
   assign blk_end = (state == S_NEXT) && last;
   assign src_cur = src;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (go_rd)      state_nx = S_RD;
            else if (go_hb) state_nx = S_HB_WAIT;
         end
         S_HB_WAIT: begin
            if (abort_hb)          state_nx = S_IDLE;
            else if (hblank_start) state_nx = S_RD;
         end
         S_RD:   state_nx = (ACCESS_WAIT == 0) ? S_WR : S_WAIT;
         S_WAIT: if (wcnt == WLAST) state_nx = S_WR;
         S_WR:   state_nx = S_NEXT;
         S_NEXT: state_nx = last ? end_sel : S_RD;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src      <= '0;
         dst      <= '0;
         wcnt     <= '0;
         dma_dout <= '0;
      end else begin
         if (load) begin
            src <= src_init;
            dst <= dst_init;
         end
         if (state == S_RD)   wcnt <= '0;
         if (state == S_WAIT) wcnt <= wcnt + 3'd1;
         // data is taken on the edge that enters WR
         if (state_nx == S_WR && state != S_WR)
            dma_dout <= dma_din;
         if (state == S_NEXT) begin
            src <= src + 16'd1;
            dst <= dst + 13'd1;
         end
      end
   end

   always_comb begin
      dma_a = '0;
      case (state)
         S_RD, S_WAIT: dma_a = src;
         S_WR:         dma_a = {3'b100, dst};
         default:      ;
      endcase
   end

   assign dma_rd = (state == S_RD);
   assign dma_wr = (state == S_WR);

endmodule

// File: rtl/hdma.sv
// CGB VRAM block-transfer unit (GDMA / HDMA) at FF51-FF55.
// Holds the MMIO registers, block count and mode/cancel control.
module hdma
   import gb_dma_pkg::*;
#(
   parameter int BLOCK_BYTES = 16,
   parameter int LEN_W       = 7,
   parameter int ACCESS_WAIT = 1
) (
   input logic   clk,
   input logic   rst,
   hdma_if.master bus
);

   localparam int LOG = $clog2(BLOCK_BYTES);

   logic [7:0]       src_hi;
   logic [7:LOG]     src_lo;
   logic [4:0]       dst_hi;
   logic [7:LOG]     dst_lo;
   logic             mode;
   logic             cancel_pend;
   logic             canceled;
   logic [LEN_W-1:0] rem;

   state_t      state;
   state_t      end_sel;
   logic        blk_end;
   logic [15:0] src_cur;
   logic        ctrl_wr;
   logic        wr_mode;
   logic        idle;
   logic        hdma_on;
   logic        start;
   logic        cancel_wr;
   logic        rearm;
   logic        last_blk;
   logic        stop;
   logic        stall;
   logic [7:0]  ctrl_rd;

   assign ctrl_wr   = bus.mmio_wr && (bus.mmio_a == REG_CTRL);
   assign wr_mode   = bus.mmio_din[MODE_BIT];
   assign idle      = (state == S_IDLE);
   assign hdma_on   = !idle && mode;
   assign start     = ctrl_wr && idle;
   assign cancel_wr = ctrl_wr && hdma_on && !wr_mode;
   assign rearm     = ctrl_wr && hdma_on && wr_mode;
   assign last_blk  = (rem == '0);
   assign stop      = cancel_wr || cancel_pend;

   always_comb begin
      end_sel = S_IDLE;
      if (rearm)         end_sel = S_HB_WAIT;
      else if (last_blk) end_sel = S_IDLE;
      else if (stop)     end_sel = S_IDLE;
      else if (!mode)    end_sel = S_RD;
      else               end_sel = S_HB_WAIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_hi      <= '0;
         src_lo      <= '0;
         dst_hi      <= '0;
         dst_lo      <= '0;
         mode        <= 1'b0;
         cancel_pend <= 1'b0;
         canceled    <= 1'b0;
         rem         <= '0;
      end else begin
         if (bus.mmio_wr) begin
            case (bus.mmio_a)
               REG_SRC_HI: src_hi <= bus.mmio_din;
               REG_SRC_LO: src_lo <= bus.mmio_din[7:LOG];
               REG_DST_HI: dst_hi <= bus.mmio_din[4:0];
               REG_DST_LO: dst_lo <= bus.mmio_din[7:LOG];
               default:    ;
            endcase
         end
         if (start) begin
            mode        <= wr_mode;
            rem         <= bus.mmio_din[LEN_W-1:0];
            cancel_pend <= 1'b0;
            canceled    <= 1'b0;
         end else if (rearm) begin
            rem         <= bus.mmio_din[LEN_W-1:0];
            cancel_pend <= 1'b0;
         end else if (cancel_wr) begin
            if (state == S_HB_WAIT) canceled    <= 1'b1;
            else                    cancel_pend <= 1'b1;
         end
         if (blk_end && !rearm) begin
            // the final decrement wraps rem to all ones
            rem         <= rem - LEN_W'(1);
            cancel_pend <= 1'b0;
            canceled    <= !last_blk && stop;
         end
      end
   end

   always_comb begin
      ctrl_rd = 8'hFF;
      if (!idle) begin
         ctrl_rd            = 8'h00;
         ctrl_rd[LEN_W-1:0] = rem;
      end else if (canceled) begin
         ctrl_rd            = 8'h80;
         ctrl_rd[LEN_W-1:0] = rem;
      end
   end

   assign bus.mmio_dout = (bus.mmio_a == REG_CTRL) ? ctrl_rd : 8'hFF;

   assign stall = (state == S_RD) || (state == S_WAIT) ||
                  (state == S_WR) || (state == S_NEXT);

   assign bus.cpu_stall         = stall;
   assign bus.dma_occupy_vidbus = stall;
   assign bus.dma_occupy_extbus = stall && (src_cur[15:13] != 3'b100);

   hdma_mover #(
      .BLOCK_BYTES (BLOCK_BYTES),
      .ACCESS_WAIT (ACCESS_WAIT)
   ) u_mover (
      .clk          (clk),
      .rst          (rst),
      .go_rd        (start && !wr_mode),
      .go_hb        (start && wr_mode),
      .abort_hb     (cancel_wr && (state == S_HB_WAIT)),
      .hblank_start (bus.hblank_start),
      .load         (start),
      .src_init     ({src_hi, src_lo, {LOG{1'b0}}}),
      .dst_init     ({dst_hi, dst_lo, {LOG{1'b0}}}),
      .end_sel      (end_sel),
      .dma_din      (bus.dma_din),
      .state        (state),
      .blk_end      (blk_end),
      .src_cur      (src_cur),
      .dma_rd       (bus.dma_rd),
      .dma_wr       (bus.dma_wr),
      .dma_a        (bus.dma_a),
      .dma_dout     (bus.dma_dout)
   );

endmodule

// File: doc/hdma.md
# hdma

CGB-style VRAM block-transfer unit (HDMA/GDMA), the parametrised successor to the OAM DMA unit. It copies blocks of BLOCK_BYTES bytes from any source address into the 8 KiB VRAM window. It runs either in general-purpose mode, which copies everything immediately with the CPU stalled, or in H-blank mode, which copies one block per H-blank pulse. It sits on the MMIO bus at FF51–FF55 and shares the external and video buses with the CPU through the occupy signals.

## Interface
Parameters:
- BLOCK_BYTES, 16: bytes per block; power of two, 2..128.
- LEN_W, 7: width of the block-count field; the maximum transfer is 2^LEN_W blocks.
- ACCESS_WAIT, 1: wait cycles between read-address issue and data capture, 0..7.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- mmio_wr  in  1  one-cycle register write strobe.
- mmio_a  in  3  register select: 0=FF51 … 4=FF55; values 5..7 are ignored.
- mmio_din  in  8  register write data.
- mmio_dout  out  8  register read data, combinational.
- hblank_start  in  1  one-cycle pulse at the start of each H-blank.
- dma_rd  out  1  bus read strobe.
- dma_wr  out  1  bus write strobe.
- dma_a  out  16  bus address.
- dma_din  in  8  bus read data.
- dma_dout  out  8  bus write data.
- cpu_stall  out  1  CPU must hold; a block is in progress.
- dma_occupy_extbus  out  1  cpu_stall and the source is outside 8000–9FFF.
- dma_occupy_vidbus  out  1  equal to cpu_stall; the destination is always VRAM.

## Operation
- **Register map:**
  - FF51/FF52 hold source high/low. The low log2(BLOCK_BYTES) bits of the source are forced to 0.
  - FF53/FF54 hold destination high/low. The destination is 8000 | dst[12:0], with the low log2(BLOCK_BYTES) bits forced to 0.
  - FF51–FF54 are write-only and read FF.
- **FF55 write:**
  - bit7 = mode (0 = GDMA, 1 = HDMA); bits[LEN_W-1:0] = block count minus 1.
  - Starting a transfer loads the internal src/dst counters from FF51–FF54.
- **FF55 read:**
  - {~active, remaining-1} while a transfer is active or paused.
  - FF once a transfer has completed, and after reset.
  - After a cancel: {1, remaining-1}.
- **States:**
  - IDLE.
  - HB_WAIT: HDMA armed, waiting for hblank_start.
  - RD: dma_rd=1, dma_a=src.
  - WAIT: ACCESS_WAIT cycles; skipped when ACCESS_WAIT=0.
  - WR: capture dma_din into dma_dout, dma_rd=0, dma_wr=1, dma_a=dst.
  - NEXT: dma_wr=0, increment counters, then branch.
- **Per-byte cycle:** RD → WAIT → WR → NEXT. After the last byte of a block, remaining is decremented.
  - If remaining wraps past 0: go to IDLE, done.
  - Else in GDMA: continue to RD.
  - Else in HDMA: go to HB_WAIT.
- **Starting:**
  - GDMA write in IDLE: go to RD on the next cycle.
  - HDMA write in IDLE: go to HB_WAIT. hblank_start in HB_WAIT moves to RD on the next cycle.
  - hblank_start in any other state is ignored.
- **Cancel:** an FF55 write with bit7=0 during an active HDMA.
  - In HB_WAIT: go to IDLE immediately.
  - Mid-block: the current block finishes, then go to IDLE.
  - src/dst counters are kept.
- **Re-arm:** an FF55 write with bit7=1 during an active HDMA reloads the remaining count and stays in HDMA. The src/dst counters are not reloaded.
- **Wrap:** src wraps modulo 2^16; dst wraps within 8000–9FFF (13-bit offset).
- **cpu_stall:** 1 in RD, WAIT, WR and NEXT; 0 in IDLE and HB_WAIT.

## Timing
- **Reset values:**
  - dma_rd, dma_wr, cpu_stall and both occupy signals = 0.
  - dma_a = 0000, dma_dout = 00.
  - All registers 0; FF55 reads FF; state IDLE.
- **Per byte:** 3 + ACCESS_WAIT cycles. A block takes BLOCK_BYTES × (3 + ACCESS_WAIT) cycles; with default parameters that is 64 cycles.
- **Start latency:** 1 cycle from the FF55 write (GDMA) or from hblank_start (HDMA) to the first dma_rd.
- **Strobes:** dma_rd and dma_wr are never high in the same cycle.
- **Reset mid-transfer:** all outputs return to reset values on the next edge, with no partial write.

## Structure
- **Shared package gb_dma_pkg:**
  - State enum.
  - Register offsets FF51–FF55.
  - HDMA mode bit index.
- **Sub-module hdma_mover:** the RD/WAIT/WR/NEXT byte engine with src/dst counters. The top level keeps the registers and block/mode control.

## Test plan
- **GDMA, 2 blocks:** src=C000, dst=8100, FF55=01.
  - 32 writes 8100–811F with data from C000–C01F.
  - cpu_stall high for 128 cycles; FF55 reads FF afterwards.
- **HDMA, 3 blocks, 3 hblank pulses:** FF55=82.
  - One 16-byte block per pulse; FF55 reads 01, 00, then FF.
  - cpu_stall low between blocks.
- **HDMA cancel:** write FF55=00 mid-block 0.
  - Block 0 completes; state goes to IDLE.
  - FF55 reads 81; later pulses cause no traffic.
- **Wrap:** src=FFF0, dst=9FF0, 2 blocks.
  - Block 2 reads 0000–000F and writes 8000–800F.
- **Reset on byte 5 of a GDMA:** next cycle dma_wr=0, dma_rd=0, cpu_stall=0, FF55 reads FF.
- **ACCESS_WAIT=0 build:** 3 cycles/byte; mmio low-bit masking verified (FF52=37 gives a source ending in 30).
